// File: rtl/rf_wb_arbiter.sv
// Purpose: round-robin share of the register-file write port plus a per-register busy scoreboard.
// Latency: 1 cycle from grant (req_valid & req_ready) to wrt/addrD/d; busy bit drops 1 cycle after commit.
// Backpressure: a source that loses arbitration sees req_ready=0 and holds; an alloc to a busy register sees alloc_ready=0.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   req_valid/addr/data (in)    NREQ writeback sources, slice i belongs to source i
//   req_ready (out)             one-hot grant, all zero when nothing is valid
//   alloc_valid/addr (in)       issue-side destination reservation
//   alloc_ready (out)           reservation accepted this cycle
//   qaddr_a/b (in)              decode read addresses
//   busy_a/b (out)              scoreboard bit of qaddr_a/b, no bypass
//   wrt, addrD, d (out)         registered register-file write port
module rf_wb_arbiter #(
   parameter int NREQ       = 3,
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
   output logic [NREQ-1:0]              req_ready,
   input  logic                         alloc_valid,
   input  logic [ADDR_WIDTH-1:0]        alloc_addr,
   output logic                         alloc_ready,
   input  logic [ADDR_WIDTH-1:0]        qaddr_a,
   input  logic [ADDR_WIDTH-1:0]        qaddr_b,
   output logic                         busy_a,
   output logic                         busy_b,
   output logic                         wrt,
   output logic [ADDR_WIDTH-1:0]        addrD,
   output logic [DATA_WIDTH-1:0]        d
);

   localparam int PW   = $clog2(NREQ);
   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [PW-1:0]   ptr;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_vld;
   logic [NREG-1:0] sb;
   logic            alloc_fire;

   // (base + off) mod NREQ; off never exceeds NREQ-1 so one subtraction suffices.
   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
      int unsigned s;
      s = int'(base) + off;
      if (s >= NREQ) s = s - NREQ;
      return s[PW-1:0];
   endfunction

   // Round-robin search starting at ptr; the first valid source wins.
   always_comb begin
      gnt_vld   = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!gnt_vld && req_valid[wrap_add(ptr, k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = wrap_add(ptr, k);
         end
      end
      if (gnt_vld) req_ready[gnt_idx] = 1'b1;
   end

   // alloc_ready looks at the pre-clear bit, so a WAW alloc stalls through the commit cycle.
   assign alloc_ready = alloc_valid & ~sb[alloc_addr];
   assign alloc_fire  = alloc_ready;

   assign busy_a = sb[qaddr_a];
   assign busy_b = sb[qaddr_b];

   // Write port and pointer: addrD/d hold when idle so the register file sees stable values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrt   <= 1'b0;
         addrD <= '0;
         d     <= '0;
         ptr   <= '0;
      end else if (gnt_vld) begin
         wrt   <= 1'b1;
         addrD <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         d     <= req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
         ptr   <= wrap_add(gnt_idx, 1);
      end else begin
         wrt   <= 1'b0;
      end
   end

   // Scoreboard: the clear lands on the commit edge (end of a wrt=1 cycle).
   // The set is written last so it wins if both target the same bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb <= '0;
      end else begin
         if (wrt)        sb[addrD]      <= 1'b0;
         if (alloc_fire) sb[alloc_addr] <= 1'b1;
      end
   end

endmodule
